aes_inv_round_seq: RTL and testbench

Parametrised sequencer for the iterative AES inverse cipher. It accepts one ciphertext block per handshake and steps the shared round datapath through its phases. The phases are the initial AddRoundKey (RoundF), NR−1 middle rounds (RoundC) and one final round (RoundD). For each cycle it drives the datapath mux select, the state/key register enables and the inverse key-expansion round index, then presents the result on a valid/ready output handshake. It replaces the fixed free-running AES-128 decryption FSM and supports 128/192/256-bit key schedules, reset, stall and flush.

---
 rtl/aes_inv_round_seq_pkg.sv | 31 +++
 rtl/aes_inv_round_seq_if.sv | 32 +++
 rtl/aes_inv_round_cnt.sv | 32 +++
 rtl/aes_inv_round_seq.sv | 131 +++++++++++++
 tb/tb_aes_inv_round_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_inv_round_seq_pkg.sv
// Shared types and constants for the iterative AES inverse-cipher sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, datapath select encodings, round counts for the
// three key sizes, and an elaboration-time legality check for NR.
package aes_inv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_MID   = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Datapath mux select: RoundF = load / initial AddRoundKey,
  // RoundC = middle round, RoundD = final round.
  localparam logic [1:0] DSEL_F = 2'b11;
  localparam logic [1:0] DSEL_C = 2'b00;
  localparam logic [1:0] DSEL_D = 2'b01;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  function automatic bit nr_legal(input int nr);
    return (nr == NR_128) || (nr == NR_192) || (nr == NR_256);
  endfunction

endpackage

// File: rtl/aes_inv_round_seq_if.sv
// Handshake and datapath-control bundle between the sequencer and its users.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
//
// Ports (master = sequencer):
//   in_valid, flush, out_ready          -> into the sequencer
//   in_ready, out_valid, busy           <- handshake / status
//   dsel, state_we, key_we, iterate     <- datapath control
interface aes_inv_round_seq_if #(
  parameter int IT_W = 8
);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [1:0]      dsel;
  logic            state_we;
  logic            key_we;
  logic [IT_W-1:0] iterate;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  modport master (
    input  in_valid, flush, out_ready,
    output in_ready, dsel, state_we, key_we, iterate, out_valid, busy
  );

  modport slave (
    output in_valid, flush, out_ready,
    input  in_ready, dsel, state_we, key_we, iterate, out_valid, busy
  );
endinterface

// File: rtl/aes_inv_round_cnt.sv
// Loadable down-counter supplying the inverse key-expansion round index.
// Latency: value updates on the clock edge after load/dec.
// Backpressure: none; load wins over dec, and dec holds at zero instead of wrapping.
//
// Ports: clk, rst_n; load + load_val (reload), dec (step down);
//        value (current count), last (value == LAST).
module aes_inv_round_cnt #(
  parameter int W    = 8,
  parameter int LAST = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign last = (value == W'(LAST));

endmodule

// File: rtl/aes_inv_round_seq.sv
// Sequencer stepping the shared AES inverse-round datapath: INIT, NR-1 MID rounds, FINAL.
// Latency: out_valid rises NR+1 cycles after the accept edge.
// Backpressure: holds DONE with stable outputs until out_ready; flush aborts at once.
//
// Ports: clk, rst_n (async, active low); sif (aes_inv_round_seq_if.master):
//   in_valid/in_ready accept a block, out_valid/out_ready hand it off,
//   flush aborts, dsel/state_we/key_we/iterate drive the datapath, busy = not IDLE.
// Option: AES_INV_BACK2BACK_EN lets DONE hand off and accept the next block in
//   the same cycle (in_ready follows out_ready in DONE).
module aes_inv_round_seq
  import aes_inv_pkg::*;
#(
  parameter int NR   = 10,
  parameter int IT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_round_seq_if.master  sif
);

  if (!nr_legal(NR)) begin : g_nr_bad
    $error("aes_inv_round_seq: NR must be 10, 12 or 14");
  end
  if (NR >= (2 ** IT_W)) begin : g_itw_bad
    $error("aes_inv_round_seq: IT_W too narrow to hold NR");
  end

  state_e          state_q;
  state_e          state_d;
  logic            cnt_load;
  logic            cnt_dec;
  logic [IT_W-1:0] cnt_val;
  logic            cnt_last;

  logic            in_ready;
  logic [1:0]      dsel;
  logic            state_we;
  logic            key_we;
  logic [IT_W-1:0] iterate;
  logic            out_valid;
  logic            busy;

  // Loaded during INIT so it reads NR in the first MID cycle; last marks
  // the MID cycle with index 2, after which FINAL uses index 1.
  aes_inv_round_cnt #(
    .W    (IT_W),
    .LAST (2)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (IT_W'(NR)),
    .dec      (cnt_dec),
    .value    (cnt_val),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    dsel      = DSEL_F;
    state_we  = 1'b0;
    key_we    = 1'b0;
    iterate   = '0;
    out_valid = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (sif.in_valid) state_d = ST_INIT;
      end
      ST_INIT: begin
        state_we = 1'b1;
        key_we   = 1'b1;
        cnt_load = 1'b1;
        state_d  = ST_MID;
      end
      ST_MID: begin
        dsel     = DSEL_C;
        state_we = 1'b1;
        key_we   = 1'b1;
        iterate  = cnt_val;
        cnt_dec  = 1'b1;
        if (cnt_last) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        dsel     = DSEL_D;
        state_we = 1'b1;
        key_we   = 1'b1;
        iterate  = IT_W'(1);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
`ifdef AES_INV_BACK2BACK_EN
        in_ready = sif.out_ready;
        if (sif.out_ready) state_d = sif.in_valid ? ST_INIT : ST_IDLE;
`else
        if (sif.out_ready) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including an accept in the same cycle.
    if (sif.flush) begin
      state_d  = ST_IDLE;
      in_ready = 1'b0;
    end
  end

  assign sif.in_ready  = in_ready;
  assign sif.dsel      = dsel;
  assign sif.state_we  = state_we;
  assign sif.key_we    = key_we;
  assign sif.iterate   = iterate;
  assign sif.out_valid = out_valid;
  assign sif.busy      = busy;

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Directed bench for aes_inv_round_seq with NR=10 and NR=14 instances.
// Expected per-cycle control words are queued when a block is launched and
// popped one per cycle as the DUT steps through its phases.
module tb_aes_inv_round_seq;

`ifdef AES_INV_BACK2BACK_EN
  localparam int GAP_ADD = 2;
`else
  localparam int GAP_ADD = 3;
`endif

  typedef struct packed {
    logic [1:0] dsel;
    logic       swe;
    logic       kwe;
    logic [7:0] it;
    logic       ov;
  } ctl_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  ctl_t sb[$];

  aes_inv_round_seq_if #(.IT_W(8)) if10 ();
  aes_inv_round_seq_if #(.IT_W(8)) if14 ();

  aes_inv_round_seq #(.NR(10), .IT_W(8)) dut10 (.clk(clk), .rst_n(rst_n), .sif(if10));
  aes_inv_round_seq #(.NR(14), .IT_W(8)) dut14 (.clk(clk), .rst_n(rst_n), .sif(if14));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t mk(input logic [1:0] d, input logic we, input int it, input logic ov);
    ctl_t c;
    c.dsel = d;
    c.swe  = we;
    c.kwe  = we;
    c.it   = it[7:0];
    c.ov   = ov;
    return c;
  endfunction

  function automatic ctl_t sample(input bit big);
    ctl_t c;
    if (big) c = {if14.dsel, if14.state_we, if14.key_we, if14.iterate, if14.out_valid};
    else     c = {if10.dsel, if10.state_we, if10.key_we, if10.iterate, if10.out_valid};
    return c;
  endfunction

  task automatic drive(input bit big, input logic iv, input logic ordy, input logic fl);
    if (big) begin
      if14.in_valid = iv; if14.out_ready = ordy; if14.flush = fl;
    end else begin
      if10.in_valid = iv; if10.out_ready = ordy; if10.flush = fl;
    end
  endtask

  function automatic logic get_rdy(input bit big);
    return big ? if14.in_ready : if10.in_ready;
  endfunction

  function automatic logic get_busy(input bit big);
    return big ? if14.busy : if10.busy;
  endfunction

  task automatic chk_reset(input string tag, input bit big);
    chk({tag, "_ctl"}, 32'(sample(big)), 32'(mk(2'b11, 1'b0, 0, 1'b0)));
    chk({tag, "_in_ready"}, 32'(get_rdy(big)), 32'd1);
    chk({tag, "_busy"}, 32'(get_busy(big)), 32'd0);
  endtask

  // Queue the whole expected trajectory, then perform the accept handshake.
  // Returns #1 after the accept edge with the DUT in INIT.
  task automatic start_block(input bit big, input int nr, input logic ordy);
    sb.push_back(mk(2'b11, 1'b1, 0, 1'b0));
    for (int i = nr; i >= 2; i--) sb.push_back(mk(2'b00, 1'b1, i, 1'b0));
    sb.push_back(mk(2'b01, 1'b1, 1, 1'b0));
    sb.push_back(mk(2'b11, 1'b0, 0, 1'b1));
    @(negedge clk);
    chk("pre_accept_in_ready", 32'(get_rdy(big)), 32'd1);
    drive(big, 1'b1, ordy, 1'b0);
    @(posedge clk); #1;
    drive(big, 1'b0, ordy, 1'b0);
  endtask

  // Compare n queued entries on consecutive cycles; ends on the last one.
  task automatic drain(input bit big, input string tag, input int n);
    ctl_t e;
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      chk($sformatf("%s_cyc%0d", tag, k + 1), 32'(sample(big)), 32'(e));
      if (k < n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int   acc10[$];
    int   acc14[$];
    bit   seen;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    #12;
    chk_reset("reset10", 1'b0);
    chk_reset("reset14", 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset("idle_after_reset", 1'b0);

    // NR=10 single block, consumer always ready.
    start_block(1'b0, 10, 1'b1);
    drain(1'b0, "nr10", 12);
    @(posedge clk); #1;
    chk("nr10_idle_busy", 32'(if10.busy), 32'd0);
    chk("nr10_idle_in_ready", 32'(if10.in_ready), 32'd1);

    // NR=14 single block.
    start_block(1'b1, 14, 1'b1);
    drain(1'b1, "nr14", 16);
    @(posedge clk); #1;
    chk("nr14_idle_busy", 32'(if14.busy), 32'd0);

    // Stall in DONE for 5 cycles.
    start_block(1'b0, 10, 1'b0);
    drain(1'b0, "stall", 12);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_hold_ctl%0d", k), 32'(sample(1'b0)), 32'(mk(2'b11, 1'b0, 0, 1'b1)));
      chk($sformatf("stall_hold_in_ready%0d", k), 32'(if10.in_ready), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("stall_release_busy", 32'(if10.busy), 32'd0);
    chk("stall_release_ov", 32'(if10.out_valid), 32'd0);
    chk("stall_release_in_ready", 32'(if10.in_ready), 32'd1);

    // Flush in the 4th MID cycle.
    start_block(1'b0, 10, 1'b1);
    drain(1'b0, "flush", 5);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    sb.delete();
    chk("flush_idle_ctl", 32'(sample(1'b0)), 32'(mk(2'b11, 1'b0, 0, 1'b0)));
    chk("flush_idle_busy", 32'(if10.busy), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      seen = seen | if10.out_valid;
    end
    chk("flush_no_out_valid", 32'(seen), 32'd0);

    // Flush coinciding with in_valid in IDLE rejects the block.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("flush_idle_in_ready", 32'(if10.in_ready), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_idle_reject_busy", 32'(if10.busy), 32'd0);

    // Normal block after flush.
    start_block(1'b0, 10, 1'b1);
    drain(1'b0, "post_flush", 12);
    @(posedge clk); #1;
    chk("post_flush_idle", 32'(if10.busy), 32'd0);

    // Asynchronous reset in FINAL.
    start_block(1'b0, 10, 1'b1);
    drain(1'b0, "arst", 11);
    sb.delete();
    #2 rst_n = 1'b0;
    #1;
    chk_reset("arst_mid_final", 1'b0);
    chk("arst_out_valid", 32'(if10.out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset("arst_after_release", 1'b0);

    // Continuous traffic: accept spacing.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (if10.in_valid && if10.in_ready) acc10.push_back(cyc);
      if (if14.in_valid && if14.in_ready) acc14.push_back(cyc);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("b2b_accepts10_enough", 32'(acc10.size() >= 3), 32'd1);
    chk("b2b_accepts14_enough", 32'(acc14.size() >= 3), 32'd1);
    if (acc10.size() >= 3) begin
      chk("b2b_gap10_a", 32'(acc10[1] - acc10[0]), 32'(10 + GAP_ADD));
      chk("b2b_gap10_b", 32'(acc10[2] - acc10[1]), 32'(10 + GAP_ADD));
    end
    if (acc14.size() >= 3) begin
      chk("b2b_gap14_a", 32'(acc14[1] - acc14[0]), 32'(14 + GAP_ADD));
      chk("b2b_gap14_b", 32'(acc14[2] - acc14[1]), 32'(14 + GAP_ADD));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
